// File: rtl/ifmap_pingpong_buffer_pkg.sv
// Shared types and helpers for the ifmap ping-pong line buffer.
package ifmap_pingpong_buffer_pkg;

   localparam int unsigned DEF_MAX_LINES = 35;
   localparam int unsigned DEF_MAX_ELEMS = 256;
   localparam int unsigned DEF_PKT_ELEMS = 8;
   localparam int unsigned DEF_CNT_W     = 8;

   localparam int unsigned LINE_W = $clog2(DEF_MAX_LINES + 1);
   localparam int unsigned ELEM_W = $clog2(DEF_MAX_ELEMS + 1);
   localparam int unsigned OFF_W  = $clog2(DEF_PKT_ELEMS) + 1;
   localparam int unsigned SUM_W  = $clog2(DEF_MAX_ELEMS) + $clog2(DEF_PKT_ELEMS) + 1;
   localparam int unsigned LPOS_W = $clog2(DEF_MAX_LINES + DEF_PKT_ELEMS + 1);

   typedef struct packed {
      logic [LINE_W-1:0]    line_count;
      logic [ELEM_W-1:0]    elem_count;
      logic [LINE_W-1:0]    overlap;
      logic [DEF_CNT_W-1:0] batch_count;
   } ifmap_cfg_t;

   typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e;
   typedef enum logic [1:0] {IDLE, COPY, FILL, WAIT} fill_state_e;

   // Write cursor wide enough to run past the last line without wrapping.
   typedef struct packed {
      logic [LPOS_W-1:0] line;
      logic [SUM_W-1:0]  elem;
   } cursor_t;

   // Step a cursor forward, wrapping lines; a step never exceeds one packet.
   function automatic cursor_t advance(cursor_t cur, logic [OFF_W-1:0] step,
                                       logic [ELEM_W-1:0] elem_count);
      cursor_t c;
      c      = cur;
      c.elem = c.elem + SUM_W'(step);
      for (int unsigned k = 0; k < DEF_PKT_ELEMS; k++) begin
         if (c.elem >= SUM_W'(elem_count)) begin
            c.elem = c.elem - SUM_W'(elem_count);
            c.line = c.line + LPOS_W'(1);
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/ifmap_pingpong_buffer_compactor.sv
// Prefix popcount of a packet byte mask: per-byte packed offset and total count.
module ifmap_pkt_compactor
   import ifmap_pingpong_buffer_pkg::*;
#(
   parameter int unsigned PKT_ELEMS = DEF_PKT_ELEMS,
   parameter int unsigned CNT_BITS  = $clog2(PKT_ELEMS) + 1
)(
   input  logic [PKT_ELEMS-1:0]               mask,
   output logic [PKT_ELEMS-1:0][CNT_BITS-1:0] offset_c,
   output logic [CNT_BITS-1:0]                count_c
);

   logic [CNT_BITS-1:0] acc;

   always_comb begin
      acc      = '0;
      offset_c = '0;
      for (int unsigned i = 0; i < PKT_ELEMS; i++) begin
         offset_c[i] = acc;
         acc         = acc + CNT_BITS'(mask[i]);
      end
      count_c = acc;
   end

endmodule

// File: rtl/ifmap_pingpong_buffer.sv
// Double-banked ifmap line buffer: fills one bank from masked packets while the
// PE array reads the other, carrying a halo of overlap lines between banks.
module ifmap_pingpong_buffer
   import ifmap_pingpong_buffer_pkg::*;
#(
   parameter int unsigned MAX_LINES = DEF_MAX_LINES,
   parameter int unsigned MAX_ELEMS = DEF_MAX_ELEMS,
   parameter int unsigned PKT_ELEMS = DEF_PKT_ELEMS,
   parameter int unsigned CNT_W     = DEF_CNT_W
)(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [$clog2(MAX_LINES+1)-1:0]     cfg_line_count,
   input  logic [$clog2(MAX_ELEMS+1)-1:0]     cfg_elem_count,
   input  logic [$clog2(MAX_LINES+1)-1:0]     cfg_overlap,
   input  logic [CNT_W-1:0]                   cfg_batch_count,
   input  logic [PKT_ELEMS*8-1:0]             pkt_data,
   input  logic [PKT_ELEMS-1:0]               pkt_mask,
   input  logic                               decomp_ack,
   input  logic                               free_bank,
   output logic                               buf_req,
   output logic [MAX_LINES*MAX_ELEMS*8-1:0]   ifmap_data,
   output logic                               ifmap_data_valid,
   output logic                               ifmap_data_change,
   output logic                               layer_done,
   output logic                               overflow_err
);

   localparam int unsigned LINE_BITS = MAX_ELEMS * 8;
   localparam int unsigned BANK_W    = MAX_LINES * LINE_BITS;

   logic [BANK_W-1:0] bank_mem [2];
   ifmap_cfg_t        cfg;
   fill_state_e       fill_st;
   bank_state_e       bank_st [2];
   logic              wr_bank, rd_bank, valid_d, rd_bank_d;
   logic [LINE_W-1:0] wr_line;
   logic [ELEM_W-1:0] wr_elem;
   logic [CNT_W-1:0]  filled_cnt, freed_cnt;

   logic [PKT_ELEMS-1:0][OFF_W-1:0] offset_c;
   logic [OFF_W-1:0]                count_c;
   cursor_t                         start_pos_c, end_pos_c;
   cursor_t                         byte_pos_c [PKT_ELEMS];
   int unsigned                     wr_idx_c [PKT_ELEMS];
   logic [PKT_ELEMS-1:0]            wr_en_c;
   logic                            transfer_c, full_c, drop_c, valid_c, src_bank_c;
   int unsigned                     src_base_c;
   logic [BANK_W-1:0]               copy_bank_c;
   logic [CNT_W-1:0]                filled_inc_c, freed_inc_c;

   ifmap_pkt_compactor #(.PKT_ELEMS(PKT_ELEMS), .CNT_BITS(OFF_W)) u_compactor (
      .mask     (pkt_mask),
      .offset_c (offset_c),
      .count_c  (count_c)
   );

   assign valid_c          = (bank_st[rd_bank] == FULL);
   assign ifmap_data_valid = valid_c;
   assign ifmap_data       = valid_c ? bank_mem[rd_bank] : '0;
   assign filled_inc_c     = filled_cnt + CNT_W'(1);
   assign freed_inc_c      = freed_cnt + CNT_W'(1);

   // Target position of every packet byte; bytes landing past the last line drop.
   always_comb begin
      transfer_c  = buf_req & decomp_ack;
      start_pos_c = '{line: LPOS_W'(wr_line), elem: SUM_W'(wr_elem)};
      end_pos_c   = advance(start_pos_c, count_c, cfg.elem_count);
      full_c      = transfer_c && (end_pos_c.line >= LPOS_W'(cfg.line_count));
      drop_c      = 1'b0;
      wr_en_c     = '0;
      for (int unsigned i = 0; i < PKT_ELEMS; i++) begin
         byte_pos_c[i] = advance(start_pos_c, offset_c[i], cfg.elem_count);
         wr_idx_c[i]   = (32'(byte_pos_c[i].line) * MAX_ELEMS + 32'(byte_pos_c[i].elem)) * 8;
         wr_en_c[i]    = transfer_c && pkt_mask[i] &&
                         (byte_pos_c[i].line < LPOS_W'(cfg.line_count));
         drop_c        = drop_c | (transfer_c && pkt_mask[i] &&
                         (byte_pos_c[i].line >= LPOS_W'(cfg.line_count)));
      end
   end

   // Next-bank image: halo lines from the just-filled bank, everything else zero.
   always_comb begin
      src_bank_c  = ~wr_bank;
      src_base_c  = 32'(cfg.line_count) - 32'(cfg.overlap);
      copy_bank_c = '0;
      for (int unsigned l = 0; l < MAX_LINES; l++) begin
         if (l < 32'(cfg.overlap))
            copy_bank_c[l*LINE_BITS +: LINE_BITS] =
               bank_mem[src_bank_c][(src_base_c + l)*LINE_BITS +: LINE_BITS];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         if (!rst_n)
            cfg <= '0;
         else
            cfg <= '{line_count:  LINE_W'(cfg_line_count),
                     elem_count:  ELEM_W'(cfg_elem_count),
                     overlap:     LINE_W'(cfg_overlap),
                     batch_count: DEF_CNT_W'(cfg_batch_count)};
         fill_st           <= IDLE;
         bank_st[0]        <= EMPTY;
         bank_st[1]        <= EMPTY;
         bank_mem[0]       <= '0;
         bank_mem[1]       <= '0;
         wr_bank           <= 1'b0;
         rd_bank           <= 1'b0;
         valid_d           <= 1'b0;
         rd_bank_d         <= 1'b0;
         wr_line           <= '0;
         wr_elem           <= '0;
         filled_cnt        <= '0;
         freed_cnt         <= '0;
         buf_req           <= 1'b0;
         ifmap_data_change <= 1'b0;
         layer_done        <= 1'b0;
         overflow_err      <= 1'b0;
      end else begin
         valid_d           <= valid_c;
         rd_bank_d         <= rd_bank;
         ifmap_data_change <= valid_c && (!valid_d || (rd_bank != rd_bank_d));

         if (free_bank && valid_c) begin
            bank_st[rd_bank] <= EMPTY;
            rd_bank          <= ~rd_bank;
            freed_cnt        <= freed_inc_c;
            if (freed_inc_c == CNT_W'(cfg.batch_count))
               layer_done <= 1'b1;
         end

         if (drop_c)
            overflow_err <= 1'b1;

         for (int unsigned i = 0; i < PKT_ELEMS; i++) begin
            if (wr_en_c[i])
               bank_mem[wr_bank][wr_idx_c[i] +: 8] <= pkt_data[8*i +: 8];
         end

         case (fill_st)
            IDLE: begin
               if (filled_cnt != CNT_W'(cfg.batch_count)) begin
                  fill_st          <= FILL;
                  buf_req          <= 1'b1;
                  bank_st[wr_bank] <= FILLING;
               end
            end
            FILL: begin
               if (transfer_c) begin
                  wr_line <= LINE_W'(end_pos_c.line);
                  wr_elem <= ELEM_W'(end_pos_c.elem);
               end
               if (full_c) begin
                  bank_st[wr_bank] <= FULL;
                  filled_cnt       <= filled_inc_c;
                  buf_req          <= 1'b0;
                  if (filled_inc_c == CNT_W'(cfg.batch_count)) begin
                     fill_st <= IDLE;
                  end else begin
                     wr_bank <= ~wr_bank;
                     fill_st <= (bank_st[src_bank_c] == EMPTY) ? COPY : WAIT;
                  end
               end
            end
            WAIT: begin
               if (bank_st[wr_bank] == EMPTY)
                  fill_st <= COPY;
            end
            COPY: begin
               bank_mem[wr_bank] <= copy_bank_c;
               bank_st[wr_bank]  <= FILLING;
               wr_line           <= cfg.overlap;
               wr_elem           <= '0;
               fill_st           <= FILL;
               buf_req           <= 1'b1;
            end
            default: fill_st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifmap_pingpong_buffer.sv
// Directed bench for ifmap_pingpong_buffer with hand-computed bank contents.
module tb_ifmap_pingpong_buffer;

   localparam int unsigned MAX_LINES = 35;
   localparam int unsigned MAX_ELEMS = 256;
   localparam int unsigned PKT_ELEMS = 8;

   logic                             clk, rst_n, start;
   logic [5:0]                       cfg_line_count, cfg_overlap;
   logic [8:0]                       cfg_elem_count;
   logic [7:0]                       cfg_batch_count;
   logic [PKT_ELEMS*8-1:0]           pkt_data;
   logic [PKT_ELEMS-1:0]             pkt_mask;
   logic                             decomp_ack, free_bank;
   logic                             buf_req, ifmap_data_valid, ifmap_data_change;
   logic                             layer_done, overflow_err;
   logic [MAX_LINES*MAX_ELEMS*8-1:0] ifmap_data;

   int n_vec = 0;
   int n_err = 0;

   ifmap_pingpong_buffer dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .cfg_line_count    (cfg_line_count),
      .cfg_elem_count    (cfg_elem_count),
      .cfg_overlap       (cfg_overlap),
      .cfg_batch_count   (cfg_batch_count),
      .pkt_data          (pkt_data),
      .pkt_mask          (pkt_mask),
      .decomp_ack        (decomp_ack),
      .free_bank         (free_bank),
      .buf_req           (buf_req),
      .ifmap_data        (ifmap_data),
      .ifmap_data_valid  (ifmap_data_valid),
      .ifmap_data_change (ifmap_data_change),
      .layer_done        (layer_done),
      .overflow_err      (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] rd_byte(input int unsigned l, input int unsigned e);
      return ifmap_data[(l*MAX_ELEMS + e)*8 +: 8];
   endfunction

   function automatic logic [63:0] ramp(input logic [7:0] base);
      logic [63:0] d;
      for (int i = 0; i < 8; i++) d[8*i +: 8] = base + 8'(i);
      return d;
   endfunction

   task automatic do_start(input int lc, input int ec, input int ovl, input int bc);
      cfg_line_count  = 6'(lc);
      cfg_elem_count  = 9'(ec);
      cfg_overlap     = 6'(ovl);
      cfg_batch_count = 8'(bc);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [63:0] data, input logic [7:0] mask);
      int n = 0;
      while (buf_req !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (buf_req !== 1'b1) begin
         check("buf_req_wait", 32'(buf_req), 32'd1);
      end else begin
         pkt_data   = data;
         pkt_mask   = mask;
         decomp_ack = 1'b1;
         tick();
         decomp_ack = 1'b0;
         pkt_mask   = '0;
      end
   endtask

   task automatic do_free();
      free_bank = 1'b1;
      tick();
      free_bank = 1'b0;
   endtask

   task automatic check_idle_outs(input string tag);
      check({tag, "_req"},    32'(buf_req),           32'd0);
      check({tag, "_valid"},  32'(ifmap_data_valid),  32'd0);
      check({tag, "_change"}, 32'(ifmap_data_change), 32'd0);
      check({tag, "_done"},   32'(layer_done),        32'd0);
      check({tag, "_ovf"},    32'(overflow_err),      32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; decomp_ack = 1'b0; free_bank = 1'b0;
      pkt_data = '0; pkt_mask = '0;
      cfg_line_count = '0; cfg_elem_count = '0; cfg_overlap = '0; cfg_batch_count = '0;
      tick();
      tick();
      check_idle_outs("rst");
      check("rst_data", 32'(rd_byte(0, 0)), 32'h0);
      rst_n = 1'b1;
      tick();

      // Basic fill with one line wrap inside a packet
      do_start(3, 5, 0, 1);
      check_idle_outs("t1_start");
      send(ramp(8'h01), 8'hFF);
      check("t1_midvalid", 32'(ifmap_data_valid), 32'd0);
      send(ramp(8'h09), 8'h7F);
      check("t1_valid",  32'(ifmap_data_valid),  32'd1);
      check("t1_chg0",   32'(ifmap_data_change), 32'd0);
      check("t1_req",    32'(buf_req),           32'd0);
      check("t1_b00",    32'(rd_byte(0, 0)), 32'h01);
      check("t1_b04",    32'(rd_byte(0, 4)), 32'h05);
      check("t1_b10",    32'(rd_byte(1, 0)), 32'h06);
      check("t1_b14",    32'(rd_byte(1, 4)), 32'h0A);
      check("t1_b20",    32'(rd_byte(2, 0)), 32'h0B);
      check("t1_b24",    32'(rd_byte(2, 4)), 32'h0F);
      check("t1_b05",    32'(rd_byte(0, 5)), 32'h00);
      check("t1_b30",    32'(rd_byte(3, 0)), 32'h00);
      tick();
      check("t1_chg1",   32'(ifmap_data_change), 32'd1);
      tick();
      check("t1_chg2",   32'(ifmap_data_change), 32'd0);
      check("t1_req2",   32'(buf_req),           32'd0);
      do_free();
      check("t1_done",   32'(layer_done),        32'd1);
      check("t1_vfree",  32'(ifmap_data_valid),  32'd0);

      // Sparse masks pack contiguously; zero mask is a no-op
      do_start(2, 8, 0, 1);
      check("t3_done_clr", 32'(layer_done), 32'd0);
      send(ramp(8'h10), 8'hA5);
      send(ramp(8'hE0), 8'h00);
      check("t3_z_valid", 32'(ifmap_data_valid), 32'd0);
      check("t3_z_req",   32'(buf_req),          32'd1);
      send(ramp(8'h20), 8'hFF);
      send(ramp(8'h30), 8'hA5);
      check("t3_valid", 32'(ifmap_data_valid), 32'd1);
      check("t3_b00",   32'(rd_byte(0, 0)), 32'h10);
      check("t3_b01",   32'(rd_byte(0, 1)), 32'h12);
      check("t3_b02",   32'(rd_byte(0, 2)), 32'h15);
      check("t3_b03",   32'(rd_byte(0, 3)), 32'h17);
      check("t3_b04",   32'(rd_byte(0, 4)), 32'h20);
      check("t3_b13",   32'(rd_byte(1, 3)), 32'h27);
      check("t3_b14",   32'(rd_byte(1, 4)), 32'h30);
      check("t3_b17",   32'(rd_byte(1, 7)), 32'h37);
      check("t3_ovf",   32'(overflow_err),  32'd0);
      do_free();

      // Final packet overruns the bank
      do_start(2, 3, 0, 1);
      send(ramp(8'h41), 8'h0F);
      check("t5_ovf0",  32'(overflow_err),     32'd0);
      send(ramp(8'h51), 8'hFF);
      check("t5_ovf1",  32'(overflow_err),     32'd1);
      check("t5_valid", 32'(ifmap_data_valid), 32'd1);
      check("t5_b00",   32'(rd_byte(0, 0)), 32'h41);
      check("t5_b02",   32'(rd_byte(0, 2)), 32'h43);
      check("t5_b03",   32'(rd_byte(0, 3)), 32'h00);
      check("t5_b10",   32'(rd_byte(1, 0)), 32'h44);
      check("t5_b11",   32'(rd_byte(1, 1)), 32'h51);
      check("t5_b12",   32'(rd_byte(1, 2)), 32'h52);
      check("t5_b20",   32'(rd_byte(2, 0)), 32'h00);
      do_free();
      check("t5_sticky", 32'(overflow_err), 32'd1);
      check("t5_done",   32'(layer_done),   32'd1);

      // Halo carry across three batches, freeing each bank
      do_start(4, 4, 2, 3);
      check("t2_ovf_clr", 32'(overflow_err), 32'd0);
      send(ramp(8'h00), 8'hFF);
      send(ramp(8'h08), 8'hFF);
      check("t2_v0",    32'(ifmap_data_valid), 32'd1);
      check("t2_a20",   32'(rd_byte(2, 0)), 32'h08);
      check("t2_a33",   32'(rd_byte(3, 3)), 32'h0F);
      do_free();
      check("t2_vf0",   32'(ifmap_data_valid), 32'd0);
      check("t2_done0", 32'(layer_done),       32'd0);
      send(ramp(8'h20), 8'hFF);
      check("t2_v1",    32'(ifmap_data_valid), 32'd1);
      check("t2_b00",   32'(rd_byte(0, 0)), 32'h08);
      check("t2_b13",   32'(rd_byte(1, 3)), 32'h0F);
      check("t2_b20",   32'(rd_byte(2, 0)), 32'h20);
      check("t2_b33",   32'(rd_byte(3, 3)), 32'h27);
      do_free();
      send(ramp(8'h30), 8'hFF);
      check("t2_v2",    32'(ifmap_data_valid), 32'd1);
      check("t2_c00",   32'(rd_byte(0, 0)), 32'h20);
      check("t2_c13",   32'(rd_byte(1, 3)), 32'h27);
      check("t2_c20",   32'(rd_byte(2, 0)), 32'h30);
      check("t2_c33",   32'(rd_byte(3, 3)), 32'h37);
      check("t2_req",   32'(buf_req),       32'd0);
      check("t2_done1", 32'(layer_done),    32'd0);
      do_free();
      check("t2_done",  32'(layer_done),    32'd1);

      // Both banks full: fill waits until a bank is freed
      do_start(2, 4, 1, 3);
      send(ramp(8'h60), 8'hFF);
      send(ramp(8'h70), 8'h0F);
      tick(); tick(); tick();
      check("t4_req",   32'(buf_req),          32'd0);
      check("t4_valid", 32'(ifmap_data_valid), 32'd1);
      check("t4_a00",   32'(rd_byte(0, 0)), 32'h60);
      check("t4_a13",   32'(rd_byte(1, 3)), 32'h67);
      do_free();
      check("t4_vnext", 32'(ifmap_data_valid),  32'd1);
      check("t4_chg0",  32'(ifmap_data_change), 32'd0);
      check("t4_b00",   32'(rd_byte(0, 0)), 32'h64);
      check("t4_b10",   32'(rd_byte(1, 0)), 32'h70);
      tick();
      check("t4_chg1",  32'(ifmap_data_change), 32'd1);
      send(ramp(8'h80), 8'h0F);
      check("t4_still", 32'(rd_byte(0, 0)), 32'h64);
      check("t4_req2",  32'(buf_req),       32'd0);
      do_free();
      check("t4_v2",    32'(ifmap_data_valid), 32'd1);
      check("t4_c00",   32'(rd_byte(0, 0)), 32'h70);
      check("t4_c03",   32'(rd_byte(0, 3)), 32'h73);
      check("t4_c10",   32'(rd_byte(1, 0)), 32'h80);
      check("t4_c13",   32'(rd_byte(1, 3)), 32'h83);
      check("t4_done",  32'(layer_done),    32'd0);

      // Start mid-fill with simultaneous ack and free
      do_start(3, 4, 0, 1);
      send(ramp(8'h90), 8'hFF);
      cfg_line_count = 6'd1; cfg_elem_count = 9'd2; cfg_overlap = 6'd0; cfg_batch_count = 8'd1;
      pkt_data = ramp(8'hC0); pkt_mask = 8'hFF; decomp_ack = 1'b1; free_bank = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0; decomp_ack = 1'b0; free_bank = 1'b0; pkt_mask = '0;
      check_idle_outs("t6_start");
      send(ramp(8'hA0), 8'h03);
      check("t6_valid", 32'(ifmap_data_valid), 32'd1);
      check("t6_b00",   32'(rd_byte(0, 0)), 32'hA0);
      check("t6_b01",   32'(rd_byte(0, 1)), 32'hA1);
      check("t6_b02",   32'(rd_byte(0, 2)), 32'h00);
      check("t6_b10",   32'(rd_byte(1, 0)), 32'h00);
      check("t6_ovf",   32'(overflow_err),  32'd0);

      // Reset mid-fill
      do_start(3, 4, 0, 1);
      send(ramp(8'hB0), 8'hFF);
      rst_n = 1'b0;
      tick();
      check_idle_outs("t6_rst");
      rst_n = 1'b1;
      tick(); tick(); tick();
      check("t6_rst_req", 32'(buf_req), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
